// File: rtl/bsg_nonsynth_dram_traffic_gen_pkg.sv
// bsg_nonsynth_dram_traffic_gen_pkg: run states and the address-derived data pattern
package bsg_nonsynth_dram_traffic_gen_pkg;

    localparam int max_data_width_lp = 1024;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WDRAIN,
        READ,
        RDRAIN,
        DONE
    } state_e;

    // lane j carries addr + j; callers truncate to their own data width
    function automatic logic [max_data_width_lp-1:0] pattern(input logic [63:0] addr, input int data_width);
        logic [max_data_width_lp-1:0] res;
        res = '0;
        for (int j = 0; j < max_data_width_lp / 32; j++)
            if (j < data_width / 32)
                res[j*32 +: 32] = addr[31:0] + 32'(j);
        return res;
    endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// bsg_counter_up_down: up/down counter with synchronous clear; simultaneous up and down cancel
module bsg_counter_up_down #(
    parameter int max_val_p = 4,
    localparam int width_lp = $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clear_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o
);

    logic [width_lp-1:0] count_d, count_q;

    always_comb count_d = clear_i ? '0 : count_q + width_lp'(up_i) - width_lp'(down_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_nonsynth_dram_traffic_gen.sv
// bsg_nonsynth_dram_traffic_gen: writes a pattern burst to one DRAM channel, then reads it back and checks it
module bsg_nonsynth_dram_traffic_gen
    import bsg_nonsynth_dram_traffic_gen_pkg::*;
#(
    parameter int          channel_addr_width_p = 16,
    parameter int          data_width_p         = 128,
    parameter int          num_reqs_p           = 8,
    parameter int unsigned start_addr_p         = 0,
    parameter int          max_outstanding_p    = 4,
    localparam int         mask_width_lp        = data_width_p >> 3
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            start_i,
    output logic                            v_o,
    output logic                            write_not_read_o,
    output logic [channel_addr_width_p-1:0] ch_addr_o,
    input  logic                            yumi_i,
    output logic                            data_v_o,
    output logic [data_width_p-1:0]         data_o,
    output logic [mask_width_lp-1:0]        mask_o,
    input  logic                            data_yumi_i,
    input  logic                            data_v_i,
    input  logic [data_width_p-1:0]         data_i,
    input  logic [channel_addr_width_p-1:0] read_done_ch_addr_i,
    input  logic                            write_done_i,
    output logic                            done_o,
    output logic                            error_o,
    output logic [31:0]                     error_count_o
);

    localparam int ow_lp = $clog2(max_outstanding_p + 1);
    localparam logic [channel_addr_width_p-1:0] step_lp  = channel_addr_width_p'(data_width_p / 8);
    localparam logic [channel_addr_width_p-1:0] start_lp = channel_addr_width_p'(start_addr_p);
    localparam logic [31:0] last_lp = 32'(num_reqs_p - 1);
    localparam logic [31:0] num_lp  = 32'(num_reqs_p);

    state_e                          state_d, state_q;
    logic [channel_addr_width_p-1:0] addr_d, addr_q;
    logic [31:0]                     req_cnt_d, req_cnt_q;
    logic [31:0]                     wdone_cnt_d, wdone_cnt_q;
    logic [31:0]                     err_cnt_d, err_cnt_q;
    logic                            err_d, err_q;
    logic [ow_lp-1:0]                outst;
    logic [data_width_p-1:0]         wr_pat, rd_pat;
    logic                            go, accept, last, rd_issue, rd_ret;
    logic                            mismatch, proto_w, proto_r, proto_d;
    logic [1:0]                      err_inc;
    logic [32:0]                     err_sum;

    assign wr_pat   = data_width_p'(pattern(64'(addr_q), data_width_p));
    assign rd_pat   = data_width_p'(pattern(64'(read_done_ch_addr_i), data_width_p));
    assign go       = start_i & (state_q == IDLE | state_q == DONE);
    assign accept   = v_o & yumi_i;
    assign last     = req_cnt_q == last_lp;
    assign rd_issue = accept & (state_q == READ);
    assign rd_ret   = data_v_i & (state_q == READ | state_q == RDRAIN) & (outst != '0);

    // responses are ignored in IDLE so traffic left over from an aborted run is harmless
    assign mismatch = rd_ret & (data_i != rd_pat);
    assign proto_w  = (state_q == WRITE) & (yumi_i != data_yumi_i);
    assign proto_r  = data_v_i & (state_q != IDLE) & ~rd_ret;
    assign proto_d  = write_done_i & (state_q != IDLE) & (wdone_cnt_q == num_lp);
    assign err_inc  = 2'(mismatch) + 2'(proto_w) + 2'(proto_r) + 2'(proto_d);
    assign err_sum  = 33'(err_cnt_q) + 33'(err_inc);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        req_cnt_d   = req_cnt_q;
        wdone_cnt_d = wdone_cnt_q + 32'(write_done_i & (state_q != IDLE) & ~proto_d);
        err_cnt_d   = err_sum[32] ? '1 : err_sum[31:0];
        err_d       = err_q | (err_inc != '0);
        if (accept & (state_q == WRITE | state_q == READ)) begin
            addr_d    = addr_q + step_lp;
            req_cnt_d = last ? '0 : req_cnt_q + 32'd1;
            if (last)
                state_d = (state_q == WRITE) ? WDRAIN : RDRAIN;
        end
        if (state_q == WDRAIN && wdone_cnt_q == num_lp) begin
            state_d = READ;
            addr_d  = start_lp;
        end
        if (state_q == RDRAIN && outst == '0)
            state_d = DONE;
        if (go) begin
            state_d     = WRITE;
            addr_d      = start_lp;
            req_cnt_d   = '0;
            wdone_cnt_d = '0;
            err_cnt_d   = '0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            addr_q      <= start_lp;
            req_cnt_q   <= '0;
            wdone_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_cnt_q   <= req_cnt_d;
            wdone_cnt_q <= wdone_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_q       <= err_d;
        end
    end

    bsg_counter_up_down #(.max_val_p(max_outstanding_p)) outst_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (go),
        .up_i      (rd_issue),
        .down_i    (rd_ret),
        .count_o   (outst)
    );

    assign v_o              = (state_q == WRITE) | (state_q == READ & outst < ow_lp'(max_outstanding_p));
    assign write_not_read_o = state_q == WRITE;
    assign data_v_o         = state_q == WRITE;
    assign data_o           = (state_q == WRITE) ? wr_pat : '0;
    assign mask_o           = '1;
    assign ch_addr_o        = addr_q;
    assign done_o           = state_q == DONE;
    assign error_o          = err_q;
    assign error_count_o    = err_cnt_q;

endmodule
